// File: rtl/fp_mul_result_buffer.sv
// Result buffer behind the FP multiplier: classifying FWFT FIFO with sticky {N,O,U} flags.
// Define FP_MUL_FLAG_CNT_EN to build the saturating per-flag event counters.
module fp_mul_result_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_result,
  input  logic                       in_u,
  input  logic                       in_o,
  input  logic                       in_n,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_result,
  output logic [2:0]                 out_flags,
  output logic [2:0]                 out_class,
  output logic [$clog2(DEPTH):0]     count,
  input  logic                       clr_sticky,
  output logic [2:0]                 sticky,
  output logic [CNT_W-1:0]           cnt_u,
  output logic [CNT_W-1:0]           cnt_o,
  output logic [CNT_W-1:0]           cnt_n
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] CLS_ZERO = 3'd0;
  localparam logic [2:0] CLS_DEN  = 3'd1;
  localparam logic [2:0] CLS_NORM = 3'd2;
  localparam logic [2:0] CLS_PINF = 3'd3;
  localparam logic [2:0] CLS_NINF = 3'd4;
  localparam logic [2:0] CLS_NAN  = 3'd5;

  function automatic logic [2:0] classify(input logic [31:0] w);
    logic [2:0] c;
    unique case (w[30:23])
      8'h00:   c = (w[22:0] == 23'd0) ? CLS_ZERO : CLS_DEN;
      8'hFF:   c = (w[22:0] != 23'd0) ? CLS_NAN : (w[31] ? CLS_NINF : CLS_PINF);
      default: c = CLS_NORM;
    endcase
    return c;
  endfunction

  logic [31:0]   res_q [DEPTH];
  logic [2:0]    flg_q [DEPTH];
  logic [2:0]    cls_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [2:0]    sticky_q, sticky_d;

  logic full, empty, push, pop;
  logic [2:0] in_flags;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready depends only on registered occupancy, so a same-cycle pop never frees a slot
  // for the push; out_* come from storage only, so a word is visible one edge after capture.
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign push     = in_valid && !full;
  assign pop      = !empty && out_ready;
  assign in_flags = {in_n, in_o, in_u};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    // Set wins over clear on a per-bit basis.
    sticky_d = (clr_sticky ? 3'b000 : sticky_q) | (push ? in_flags : 3'b000);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sticky_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      res_q[wr_ptr_q] <= in_result;
      flg_q[wr_ptr_q] <= in_flags;
      cls_q[wr_ptr_q] <= classify(in_result);
    end
  end

  assign in_ready   = !full;
  assign out_valid  = !empty;
  assign out_result = empty ? 32'd0 : res_q[rd_ptr_q];
  assign out_flags  = empty ? 3'd0  : flg_q[rd_ptr_q];
  assign out_class  = empty ? 3'd0  : cls_q[rd_ptr_q];
  assign count      = count_q;
  assign sticky     = sticky_q;

`ifdef FP_MUL_FLAG_CNT_EN
  logic [CNT_W-1:0] cnt_u_q, cnt_u_d;
  logic [CNT_W-1:0] cnt_o_q, cnt_o_d;
  logic [CNT_W-1:0] cnt_n_q, cnt_n_d;

  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                input logic clr, input logic inc);
    logic [CNT_W-1:0] base;
    base = clr ? '0 : cur;
    if (inc && (base != {CNT_W{1'b1}})) base = base + CNT_W'(1);
    return base;
  endfunction

  always_comb begin
    cnt_u_d = cnt_next(cnt_u_q, clr_sticky, push && in_u);
    cnt_o_d = cnt_next(cnt_o_q, clr_sticky, push && in_o);
    cnt_n_d = cnt_next(cnt_n_q, clr_sticky, push && in_n);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_u_q <= '0;
      cnt_o_q <= '0;
      cnt_n_q <= '0;
    end else begin
      cnt_u_q <= cnt_u_d;
      cnt_o_q <= cnt_o_d;
      cnt_n_q <= cnt_n_d;
    end
  end

  assign cnt_u = cnt_u_q;
  assign cnt_o = cnt_o_q;
  assign cnt_n = cnt_n_q;
`else
  assign cnt_u = '0;
  assign cnt_o = '0;
  assign cnt_n = '0;
`endif

endmodule

// File: tb/tb_fp_mul_result_buffer.sv
// Directed bench for fp_mul_result_buffer: reference occupancy/flag model plus an expected-entry queue.
module tb_fp_mul_result_buffer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 2;
  localparam int W     = 38;  // {result, {n,o,u}, class}

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_result;
  logic              in_u, in_o, in_n;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_result;
  logic [2:0]        out_flags;
  logic [2:0]        out_class;
  logic [2:0]        count;
  logic              clr_sticky;
  logic [2:0]        sticky;
  logic [CNT_W-1:0]  cnt_u, cnt_o, cnt_n;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [W-1:0]      exp_q[$];
  int                m_cnt;
  logic [2:0]        m_sticky;
  logic [CNT_W-1:0]  m_cu, m_co, m_cn;

  fp_mul_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_u(in_u), .in_o(in_o), .in_n(in_n),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .out_class(out_class), .count(count),
    .clr_sticky(clr_sticky), .sticky(sticky),
    .cnt_u(cnt_u), .cnt_o(cnt_o), .cnt_n(cnt_n)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] ref_class(input logic [31:0] w);
    logic [7:0]  e;
    logic [22:0] m;
    e = w[30:23];
    m = w[22:0];
    if (e == 8'd0) return (m == 23'd0) ? 3'd0 : 3'd1;
    if (e != 8'hFF) return 3'd2;
    if (m != 23'd0) return 3'd5;
    return w[31] ? 3'd4 : 3'd3;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic clr, input logic inc);
    logic [CNT_W-1:0] b;
    b = clr ? '0 : c;
    if (inc && b != {CNT_W{1'b1}}) b = b + 1'b1;
    return b;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_cnt    = 0;
    m_sticky = 3'b000;
    m_cu     = '0;
    m_co     = '0;
    m_cn     = '0;
  endtask

  // Scoreboard: inputs are stable from posedge+1 to the next posedge, so decide transfers on negedge.
  always @(negedge clk) begin
    logic         do_push, do_pop;
    logic [W-1:0] head;
    if (rst_n) begin
      do_push = in_valid && (m_cnt < DEPTH);
      do_pop  = out_ready && (m_cnt > 0);
      check("count",     64'(count),     64'(m_cnt));
      check("in_ready",  64'(in_ready),  64'(m_cnt < DEPTH));
      check("out_valid", 64'(out_valid), 64'(m_cnt > 0));
      check("sticky",    64'(sticky),    64'(m_sticky));
      check("cnt_u",     64'(cnt_u),     64'(m_cu));
      check("cnt_o",     64'(cnt_o),     64'(m_co));
      check("cnt_n",     64'(cnt_n),     64'(m_cn));
      if (m_cnt == 0) begin
        check("empty_out", 64'({out_result, out_flags, out_class}), 64'(0));
      end else begin
        head = exp_q[0];
        check("head", 64'({out_result, out_flags, out_class}), 64'(head));
      end
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({in_result, in_n, in_o, in_u, ref_class(in_result)});
      if (do_push && !do_pop) m_cnt++;
      else if (do_pop && !do_push) m_cnt--;
      m_sticky = (clr_sticky ? 3'b000 : m_sticky) | (do_push ? {in_n, in_o, in_u} : 3'b000);
`ifdef FP_MUL_FLAG_CNT_EN
      m_cu = sat_inc(m_cu, clr_sticky, do_push && in_u);
      m_co = sat_inc(m_co, clr_sticky, do_push && in_o);
      m_cn = sat_inc(m_cn, clr_sticky, do_push && in_n);
`endif
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic [2:0] nou);
    in_valid  = v;
    in_result = w;
    {in_n, in_o, in_u} = nou;
  endtask

  logic [31:0] cls_words [6];
  logic [2:0]  cls_exp   [6];

  initial begin
    cls_words = '{32'h3F800000, 32'h00000001, 32'h80000000, 32'h7F800000, 32'hFF800000, 32'h7FC00000};
    cls_exp   = '{3'd2, 3'd1, 3'd0, 3'd3, 3'd4, 3'd5};

    rst_n = 1'b0;
    out_ready = 1'b0;
    clr_sticky = 1'b0;
    drive(1'b0, 32'd0, 3'b000);
    model_reset();
    #12;
    check("rst_count",     64'(count), 64'(0));
    check("rst_in_ready",  64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out",       64'({out_result, out_flags, out_class}), 64'(0));
    check("rst_cnts",      64'({cnt_u, cnt_o, cnt_n, sticky}), 64'(0));
    rst_n = 1'b1;

    // Classification and 1-cycle latency, draining one per cycle
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, cls_words[i], 3'b000);
      tick();
      check("cls_valid",  64'(out_valid),  64'(1));
      check("cls_result", 64'(out_result), 64'(cls_words[i]));
      check("cls_class",  64'(out_class),  64'(cls_exp[i]));
    end
    drive(1'b0, 32'd0, 3'b000);
    tick();
    check("cls_drained", 64'(count), 64'(0));

    // Full and back-pressure
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h41000000 + 32'(i), 3'b000);
      tick();
    end
    drive(1'b1, 32'h40000000, 3'b000);
    tick();
    check("full_count",    64'(count),    64'(4));
    check("full_in_ready", 64'(in_ready), 64'(0));
    tick();
    check("full_hold",     64'(count),    64'(4));
    out_ready = 1'b1;
    tick();
    check("bp_count",      64'(count),    64'(3));
    check("bp_in_ready",   64'(in_ready), 64'(1));
    out_ready = 1'b0;
    tick();
    check("bp_fifth",      64'(count),    64'(4));
    drive(1'b0, 32'd0, 3'b000);
    out_ready = 1'b1;
    repeat (5) tick();

    // Simultaneous push and pop at count 2, crossing pointer wrap
    out_ready = 1'b0;
    drive(1'b1, 32'hC0000000, 3'b000); tick();
    drive(1'b1, 32'h00400000, 3'b000); tick();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h3E000000 + 32'($urandom_range(0, 255)), 3'b000);
      tick();
      check("pp_count", 64'(count), 64'(2));
    end
    drive(1'b0, 32'd0, 3'b000);
    repeat (3) tick();

    // Sticky flags: set, then clear with same-cycle set
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    drive(1'b1, 32'h3F800000, 3'b010);
    tick();
    check("sticky_set", 64'(sticky), 64'(3'b010));
    clr_sticky = 1'b1;
    drive(1'b1, 32'h00000001, 3'b001);
    tick();
    check("sticky_clr_set", 64'(sticky), 64'(3'b001));
    clr_sticky = 1'b0;
    drive(1'b0, 32'd0, 3'b000);
    repeat (3) tick();

    // Flag counters: five overflow pushes
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h7F800000, 3'b010);
      tick();
    end
    drive(1'b0, 32'd0, 3'b000);
`ifdef FP_MUL_FLAG_CNT_EN
    check("cnt_o_sat", 64'(cnt_o), 64'(3));
`else
    check("cnt_o_off", 64'(cnt_o), 64'(0));
`endif
    check("cnt_u_zero", 64'(cnt_u), 64'(0));
    check("cnt_n_zero", 64'(cnt_n), 64'(0));
    repeat (3) tick();

    // Asynchronous reset with three entries held
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h7FC00001 + 32'(i), 3'b100);
      tick();
    end
    drive(1'b0, 32'd0, 3'b000);
    check("pre_rst_count", 64'(count), 64'(3));
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_out_valid", 64'(out_valid), 64'(0));
    check("arst_count",     64'(count),     64'(0));
    check("arst_sticky",    64'(sticky),    64'(0));
    check("arst_in_ready",  64'(in_ready),  64'(1));
    #4;
    rst_n = 1'b1;
    tick();
    drive(1'b1, 32'h3F800000, 3'b000);
    tick();
    drive(1'b0, 32'd0, 3'b000);
    check("post_rst_valid",  64'(out_valid),  64'(1));
    check("post_rst_result", 64'(out_result), 64'(32'h3F800000));
    out_ready = 1'b1;
    repeat (2) tick();
    check("final_empty", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
